// File: rtl/pe_dbw.sv
// Weight-stationary systolic PE with double-buffered (shadow/active) weights and a
// signed/unsigned multiply-accumulate. The MAC can saturate and sets a sticky overflow flag.
module pe_dbw #(
    parameter int          DATA_WIDTH = 8,
    parameter int          PSUM_WIDTH = 32,
    parameter int unsigned SIGNED     = 1,
    parameter int unsigned SATURATE   = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] weight_i,
    input  logic                  weight_en_i,
    input  logic                  weight_swap_i,
    input  logic [DATA_WIDTH-1:0] ifmap_i,
    input  logic                  ifmap_en_i,
    input  logic [PSUM_WIDTH-1:0] psum_i,
    input  logic                  psum_en_i,
    input  logic                  clr_ovf_i,
    output logic [DATA_WIDTH-1:0] weight_o,
    output logic                  weight_en_o,
    output logic                  weight_swap_o,
    output logic [DATA_WIDTH-1:0] ifmap_o,
    output logic                  ifmap_en_o,
    output logic [PSUM_WIDTH-1:0] psum_o,
    output logic                  psum_en_o,
    output logic                  ovf_o
);

    localparam int PW = PSUM_WIDTH;
    localparam int DW = DATA_WIDTH;
    localparam int PROD_W = 2 * DW;

    // ---------------------------------------------------------------------
    // State
    // ---------------------------------------------------------------------
    logic [DW-1:0] shadow_q, shadow_d;
    logic [DW-1:0] active_q, active_d;
    logic          active_vld_q, active_vld_d;

    logic [DW-1:0] weight_q, weight_d;
    logic          weight_en_q, weight_en_d;
    logic          weight_swap_q, weight_swap_d;
    logic [DW-1:0] ifmap_q, ifmap_d;
    logic          ifmap_en_q, ifmap_en_d;
    logic [PW-1:0] psum_q, psum_d;
    logic          psum_en_q, psum_en_d;
    logic          ovf_q, ovf_d;

    // ---------------------------------------------------------------------
    // Datapath: operand extension, product, wide sum, overflow detection
    // ---------------------------------------------------------------------
    logic [DW-1:0]     w_eff;
    logic [PROD_W-1:0] w_ext;
    logic [PROD_W-1:0] x_ext;
    logic [PROD_W-1:0] prod;
    logic [PW:0]       prod_ext;
    logic [PW:0]       prod_gated;
    logic [PW:0]       psum_ext;
    logic [PW:0]       sum_full;
    logic              sum_ovf;
    logic [PW-1:0]     sat_val;
    logic [PW-1:0]     mac_result;

    // A PE that has never been swapped since reset behaves as if its weight were zero.
    assign w_eff = active_vld_q ? active_q : '0;

    generate
        if (SIGNED != 0) begin : g_signed
            // Low 2*DW bits of a product of sign-extended operands equal the signed product.
            assign w_ext    = {{DW{w_eff[DW-1]}}, w_eff};
            assign x_ext    = {{DW{ifmap_i[DW-1]}}, ifmap_i};
            assign prod_ext = {{(PW + 1 - PROD_W){prod[PROD_W-1]}}, prod};
            assign psum_ext = {psum_i[PW-1], psum_i};
            assign sum_ovf  = sum_full[PW] ^ sum_full[PW-1];
            assign sat_val  = sum_full[PW] ? {1'b1, {(PW - 1){1'b0}}}
                                           : {1'b0, {(PW - 1){1'b1}}};
        end else begin : g_unsigned
            assign w_ext    = {{DW{1'b0}}, w_eff};
            assign x_ext    = {{DW{1'b0}}, ifmap_i};
            assign prod_ext = {{(PW + 1 - PROD_W){1'b0}}, prod};
            assign psum_ext = {1'b0, psum_i};
            assign sum_ovf  = sum_full[PW];
            assign sat_val  = {PW{1'b1}};
        end
    endgenerate

    assign prod = w_ext * x_ext;

    // A bubble (no ifmap) passes psum_i through; a zero addend can never overflow.
    assign prod_gated = ifmap_en_i ? prod_ext : '0;
    assign sum_full   = psum_ext + prod_gated;

    generate
        if (SATURATE != 0) begin : g_sat
            assign mac_result = sum_ovf ? sat_val : sum_full[PW-1:0];
        end else begin : g_wrap
            assign mac_result = sum_full[PW-1:0];
        end
    endgenerate

    // ---------------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------------
    always_comb begin
        shadow_d      = shadow_q;
        active_d      = active_q;
        active_vld_d  = active_vld_q;
        weight_d      = weight_i;
        weight_en_d   = weight_en_i;
        weight_swap_d = weight_swap_i;
        ifmap_d       = ifmap_i;
        ifmap_en_d    = ifmap_en_i;
        psum_d        = psum_q;
        psum_en_d     = psum_en_i;
        ovf_d         = ovf_q;

        // Load and swap in one cycle: active takes the old shadow value.
        if (weight_swap_i) begin
            active_d     = shadow_q;
            active_vld_d = 1'b1;
        end
        if (weight_en_i) begin
            shadow_d = weight_i;
        end

        if (psum_en_i) begin
            psum_d = mac_result;
        end

        // Clear first so a simultaneous overflow wins.
        if (clr_ovf_i) begin
            ovf_d = 1'b0;
        end
        if (psum_en_i && sum_ovf) begin
            ovf_d = 1'b1;
        end
    end

    // ---------------------------------------------------------------------
    // Registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q      <= '0;
            active_q      <= '0;
            active_vld_q  <= 1'b0;
            weight_q      <= '0;
            weight_en_q   <= 1'b0;
            weight_swap_q <= 1'b0;
            ifmap_q       <= '0;
            ifmap_en_q    <= 1'b0;
            psum_q        <= '0;
            psum_en_q     <= 1'b0;
            ovf_q         <= 1'b0;
        end else begin
            shadow_q      <= shadow_d;
            active_q      <= active_d;
            active_vld_q  <= active_vld_d;
            weight_q      <= weight_d;
            weight_en_q   <= weight_en_d;
            weight_swap_q <= weight_swap_d;
            ifmap_q       <= ifmap_d;
            ifmap_en_q    <= ifmap_en_d;
            psum_q        <= psum_d;
            psum_en_q     <= psum_en_d;
            ovf_q         <= ovf_d;
        end
    end

    assign weight_o      = weight_q;
    assign weight_en_o   = weight_en_q;
    assign weight_swap_o = weight_swap_q;
    assign ifmap_o       = ifmap_q;
    assign ifmap_en_o    = ifmap_en_q;
    assign psum_o        = psum_q;
    assign psum_en_o     = psum_en_q;
    assign ovf_o         = ovf_q;

endmodule

// File: tb/tb_pe_dbw.sv
// Bench for pe_dbw: one signed/saturating and one unsigned/wrapping instance share stimulus;
// an integer-arithmetic model is compared every cycle, plus hand-computed literal checks.
module tb_pe_dbw;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  weight_i;
    logic        weight_en_i, weight_swap_i;
    logic [7:0]  ifmap_i;
    logic        ifmap_en_i;
    logic [31:0] psum_i;
    logic        psum_en_i, clr_ovf_i;

    // index 0: SIGNED=1 SATURATE=1, index 1: SIGNED=0 SATURATE=0
    logic [7:0]  w_o [2];
    logic        wen_o [2];
    logic        swp_o [2];
    logic [7:0]  x_o [2];
    logic        xen_o [2];
    logic [31:0] p_o [2];
    logic        pen_o [2];
    logic        ovf_o [2];

    int n_vec = 0;
    int n_err = 0;
    bit cmp_on = 1'b0;

    always #5 clk = ~clk;

    pe_dbw #(.DATA_WIDTH(8), .PSUM_WIDTH(32), .SIGNED(1), .SATURATE(1)) dut_s (
        .clk(clk), .rst_n(rst_n),
        .weight_i(weight_i), .weight_en_i(weight_en_i), .weight_swap_i(weight_swap_i),
        .ifmap_i(ifmap_i), .ifmap_en_i(ifmap_en_i),
        .psum_i(psum_i), .psum_en_i(psum_en_i), .clr_ovf_i(clr_ovf_i),
        .weight_o(w_o[0]), .weight_en_o(wen_o[0]), .weight_swap_o(swp_o[0]),
        .ifmap_o(x_o[0]), .ifmap_en_o(xen_o[0]),
        .psum_o(p_o[0]), .psum_en_o(pen_o[0]), .ovf_o(ovf_o[0])
    );

    pe_dbw #(.DATA_WIDTH(8), .PSUM_WIDTH(32), .SIGNED(0), .SATURATE(0)) dut_u (
        .clk(clk), .rst_n(rst_n),
        .weight_i(weight_i), .weight_en_i(weight_en_i), .weight_swap_i(weight_swap_i),
        .ifmap_i(ifmap_i), .ifmap_en_i(ifmap_en_i),
        .psum_i(psum_i), .psum_en_i(psum_en_i), .clr_ovf_i(clr_ovf_i),
        .weight_o(w_o[1]), .weight_en_o(wen_o[1]), .weight_swap_o(swp_o[1]),
        .ifmap_o(x_o[1]), .ifmap_en_o(xen_o[1]),
        .psum_o(p_o[1]), .psum_en_o(pen_o[1]), .ovf_o(ovf_o[1])
    );

    // ------------------------------------------------------------------
    // Behavioural model
    // ------------------------------------------------------------------
    logic [7:0]  m_shadow, m_active, m_w, m_x, wv;
    logic        m_vld, m_wen, m_swp, m_xen, m_pen;
    logic [31:0] m_psum [2];
    logic        m_ovf [2];
    longint      prod_s, prod_u, sum_s, sum_u;
    bit          ev_s, ev_u;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_shadow = 0; m_active = 0; m_vld = 0;
            m_w = 0; m_wen = 0; m_swp = 0; m_x = 0; m_xen = 0; m_pen = 0;
            for (int k = 0; k < 2; k++) begin
                m_psum[k] = 0;
                m_ovf[k]  = 0;
            end
        end else begin
            ev_s = 0;
            ev_u = 0;
            if (psum_en_i) begin
                wv     = m_vld ? m_active : 8'd0;
                prod_s = ifmap_en_i ? longint'($signed(wv)) * longint'($signed(ifmap_i)) : 0;
                prod_u = ifmap_en_i ? longint'(wv) * longint'(ifmap_i) : 0;
                sum_s  = longint'($signed(psum_i)) + prod_s;
                sum_u  = longint'(psum_i) + prod_u;
                if (sum_s > 64'sd2147483647) begin
                    m_psum[0] = 32'h7FFF_FFFF; ev_s = 1;
                end else if (sum_s < -64'sd2147483648) begin
                    m_psum[0] = 32'h8000_0000; ev_s = 1;
                end else begin
                    m_psum[0] = sum_s[31:0];
                end
                ev_u      = (sum_u > 64'sd4294967295);
                m_psum[1] = sum_u[31:0];
            end
            if (clr_ovf_i) begin
                m_ovf[0] = 0;
                m_ovf[1] = 0;
            end
            if (ev_s) m_ovf[0] = 1;
            if (ev_u) m_ovf[1] = 1;
            m_pen = psum_en_i;
            m_w = weight_i; m_wen = weight_en_i; m_swp = weight_swap_i;
            m_x = ifmap_i;  m_xen = ifmap_en_i;
            if (weight_swap_i) begin
                m_active = m_shadow;
                m_vld    = 1;
            end
            if (weight_en_i) m_shadow = weight_i;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // Per-cycle compare against the model
    always @(negedge clk) begin
        if (cmp_on) begin
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("model[%0d] weight_o", k), 32'(w_o[k]), 32'(m_w));
                chk($sformatf("model[%0d] weight_en_o", k), 32'(wen_o[k]), 32'(m_wen));
                chk($sformatf("model[%0d] weight_swap_o", k), 32'(swp_o[k]), 32'(m_swp));
                chk($sformatf("model[%0d] ifmap_o", k), 32'(x_o[k]), 32'(m_x));
                chk($sformatf("model[%0d] ifmap_en_o", k), 32'(xen_o[k]), 32'(m_xen));
                chk($sformatf("model[%0d] psum_en_o", k), 32'(pen_o[k]), 32'(m_pen));
                chk($sformatf("model[%0d] psum_o", k), p_o[k], m_psum[k]);
                chk($sformatf("model[%0d] ovf_o", k), 32'(ovf_o[k]), 32'(m_ovf[k]));
            end
        end
    end

    // ------------------------------------------------------------------
    // Directed stimulus
    // ------------------------------------------------------------------
    task automatic drv(input logic wen, input logic [7:0] w, input logic swp,
                       input logic xen, input logic [7:0] x,
                       input logic pen, input logic [31:0] p, input logic clr);
        weight_en_i = wen; weight_i = w; weight_swap_i = swp;
        ifmap_en_i = xen;  ifmap_i = x;
        psum_en_i = pen;   psum_i = p;   clr_ovf_i = clr;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        for (int k = 0; k < 2; k++) begin
            chk({tag, " psum_o"}, p_o[k], 32'd0);
            chk({tag, " psum_en_o"}, 32'(pen_o[k]), 32'd0);
            chk({tag, " weight_o"}, 32'(w_o[k]), 32'd0);
            chk({tag, " weight_en_o"}, 32'(wen_o[k]), 32'd0);
            chk({tag, " ifmap_o"}, 32'(x_o[k]), 32'd0);
            chk({tag, " ovf_o"}, 32'(ovf_o[k]), 32'd0);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        drv(0, 8'd0, 0, 0, 8'd0, 0, 32'd0, 0);
        #3;
        chk_all_zero("reset");
        cyc(); cyc();
        rst_n  = 1'b1;
        cmp_on = 1'b1;

        // No weight swapped since reset: product is zero; then bubble; then hold
        drv(0, 8'd0, 0, 1, 8'd9, 1, 32'd4, 0); cyc();
        chk("noweight psum_o", p_o[0], 32'd4);
        chk("noweight psum_o unsigned", p_o[1], 32'd4);
        chk("noweight psum_en_o", 32'(pen_o[0]), 32'd1);
        drv(0, 8'd0, 0, 0, 8'd0, 1, 32'd7, 0); cyc();
        chk("bubble psum_o", p_o[0], 32'd7);
        drv(0, 8'd0, 0, 0, 8'd0, 0, 32'd99, 0); cyc();
        chk("hold psum_o", p_o[0], 32'd7);
        chk("hold psum_en_o", 32'(pen_o[0]), 32'd0);

        // Basic MAC with weight 10
        drv(1, 8'd10, 0, 0, 8'd0, 0, 32'd0, 0); cyc();
        drv(0, 8'd0, 1, 0, 8'd0, 0, 32'd0, 0); cyc();
        drv(0, 8'd0, 0, 1, 8'd11, 1, 32'd1, 0); cyc();
        chk("basic psum_o 111", p_o[0], 32'd111);
        chk("basic ifmap_o 11", 32'(x_o[0]), 32'd11);
        drv(0, 8'd0, 0, 1, 8'd22, 1, 32'd2, 0); cyc();
        chk("basic psum_o 222", p_o[0], 32'd222);
        chk("basic ifmap_o 22", 32'(x_o[0]), 32'd22);
        chk("basic psum_en_o", 32'(pen_o[0]), 32'd1);

        // Double buffering: shadow load during stream, swap alongside a MAC
        drv(1, 8'd3, 0, 1, 8'd1, 1, 32'd0, 0); cyc();
        chk("dbuf load keeps active", p_o[0], 32'd10);
        drv(0, 8'd0, 1, 1, 8'd1, 1, 32'd0, 0); cyc();
        chk("dbuf swap uses old", p_o[0], 32'd10);
        drv(0, 8'd0, 0, 1, 8'd1, 1, 32'd0, 0); cyc();
        chk("dbuf new active", p_o[0], 32'd3);

        // Signedness: weight 0xFE times 5
        drv(1, 8'hFE, 0, 0, 8'd0, 0, 32'd0, 0); cyc();
        drv(0, 8'd0, 1, 0, 8'd0, 0, 32'd0, 0); cyc();
        drv(0, 8'd0, 0, 1, 8'd5, 1, 32'd0, 0); cyc();
        chk("signed -10", p_o[0], 32'hFFFF_FFF6);
        chk("unsigned 1270", p_o[1], 32'd1270);

        // Saturation and sticky overflow
        drv(1, 8'd127, 0, 0, 8'd0, 0, 32'd0, 0); cyc();
        drv(0, 8'd0, 1, 0, 8'd0, 0, 32'd0, 0); cyc();
        drv(0, 8'd0, 0, 1, 8'd127, 1, 32'h7FFF_FFF0, 0); cyc();
        chk("sat max psum_o", p_o[0], 32'h7FFF_FFFF);
        chk("sat max ovf_o", 32'(ovf_o[0]), 32'd1);
        chk("unsigned no ovf psum_o", p_o[1], 32'h8000_3EF1);
        chk("unsigned no ovf ovf_o", 32'(ovf_o[1]), 32'd0);
        drv(0, 8'd0, 0, 0, 8'd0, 0, 32'd0, 0); cyc();
        chk("ovf sticky", 32'(ovf_o[0]), 32'd1);
        drv(0, 8'd0, 0, 1, 8'd127, 1, 32'h7FFF_FFF0, 1); cyc();
        chk("ovf set beats clr", 32'(ovf_o[0]), 32'd1);
        drv(0, 8'd0, 0, 0, 8'd0, 0, 32'd0, 1); cyc();
        chk("ovf cleared", 32'(ovf_o[0]), 32'd0);
        drv(0, 8'd0, 0, 1, 8'd127, 1, 32'hFFFF_FFF0, 0); cyc();
        chk("wrap psum_o", p_o[1], 32'h0000_3EF1);
        chk("wrap ovf_o", 32'(ovf_o[1]), 32'd1);
        chk("signed small psum_o", p_o[0], 32'h0000_3EF1);
        chk("signed small ovf_o", 32'(ovf_o[0]), 32'd0);
        drv(0, 8'd0, 0, 1, 8'hFF, 1, 32'h8000_0000, 0); cyc();
        chk("sat min psum_o", p_o[0], 32'h8000_0000);
        chk("sat min ovf_o", 32'(ovf_o[0]), 32'd1);
        chk("unsigned min-case psum_o", p_o[1], 32'h8000_7E81);

        // Asynchronous reset mid-operation
        drv(1, 8'd7, 0, 1, 8'd2, 1, 32'd5, 0); cyc();
        chk("pre-reset psum_o", p_o[0], 32'd259);
        rst_n = 1'b0;
        #1;
        chk_all_zero("async reset");
        cyc();
        rst_n = 1'b1;
        drv(0, 8'd0, 0, 1, 8'd9, 1, 32'd4, 0); cyc();
        chk("post-reset no weight", p_o[0], 32'd4);
        drv(0, 8'd0, 1, 0, 8'd0, 0, 32'd0, 0); cyc();
        drv(0, 8'd0, 0, 1, 8'd9, 1, 32'd4, 0); cyc();
        chk("post-reset shadow cleared", p_o[0], 32'd4);
        chk("post-reset shadow cleared unsigned", p_o[1], 32'd4);

        drv(0, 8'd0, 0, 0, 8'd0, 0, 32'd0, 0); cyc(); cyc();
        cmp_on = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
